// File: rtl/bin2bcd_seq_if.sv
// Request/result handshake bundle for bin2bcd_seq.
// The master issues conversion requests and consumes results; the slave is the converter.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  ovf;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, neg, ovf
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, neg, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIG_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   work_sr;
  logic [DIG_W-1:0]   dig;
  logic [DIG_W-1:0]   dig_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_w;
  logic [DIG_W-1:0]   bcd_r;
  logic               ovf_r;
  logic               out_valid_r;
  logic [BIN_W-1:0]   bin_mag;

`ifdef BIN2BCD_SIGNED_EN
  logic               bin_neg;
  logic               neg_w;
  logic               neg_r;

  // The most-negative input negates to itself, which read unsigned is exactly 2^(BIN_W-1).
  assign bin_neg = bus.bin[BIN_W-1];
  assign bin_mag = bin_neg ? (~bus.bin + BIN_W'(1)) : bus.bin;
  assign bus.neg = neg_r;
`else
  assign bin_mag = bus.bin;
  assign bus.neg = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    dig_adj = dig;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig[4*i +: 4] > 4'd4) dig_adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.bcd       = bcd_r;
  assign bus.ovf       = ovf_r;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      work_sr     <= '0;
      dig         <= '0;
      cnt         <= '0;
      ovf_w       <= 1'b0;
      bcd_r       <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      neg_w       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work_sr <= bin_mag;
            dig     <= '0;
            cnt     <= '0;
            ovf_w   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            neg_w   <= bin_neg;
`endif
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // One extra SHIFT cycle at cnt==BIN_W publishes the result, giving a BIN_W+1 latency.
          if (cnt == CNT_W'(BIN_W)) begin
            bcd_r       <= dig;
            ovf_r       <= ovf_w;
`ifdef BIN2BCD_SIGNED_EN
            neg_r       <= neg_w;
`endif
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            dig     <= {dig_adj[DIG_W-2:0], work_sr[BIN_W-1]};
            work_sr <= {work_sr[BIN_W-2:0], 1'b0};
            ovf_w   <= ovf_w | dig_adj[DIG_W-1];
            cnt     <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
